// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI byte front end and the command decoder behind it.
package spi_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'h00;

  // Command byte layout, consumed by the downstream command decoder.
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 2;
  localparam int CMD_ADDR_LSB  = 0;
  localparam int NUM_PWM_CH    = 7;

  localparam int BIT_CNT_W     = 3;
  localparam int RX_INDEX_W    = 4;

  // Frame state: IDLE while cs_n is high, ACTIVE while it is low.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // Byte-position counter that sticks at its maximum instead of wrapping.
  function automatic logic [RX_INDEX_W-1:0] sat_inc(input logic [RX_INDEX_W-1:0] v);
    return (v == {RX_INDEX_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_bit.sv
// Multi-flop synchroniser for one raw asynchronous input, with a selectable reset level.
module spi_sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_byte_frontend.sv
// SPI mode-0 slave front end: synchronises raw SPI pins, deframes MOSI bytes and
// serialises reply bytes onto MISO, presenting a byte-level interface to the command logic.
module spi_byte_frontend
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter bit TX_MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic [RX_INDEX_W-1:0] rx_index,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  frame_abort,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_underrun
);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d_q, cs_n_d_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RX_INDEX_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [SPI_BYTE_W-2:0]    rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]    tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]    rx_data_q, rx_data_d;
  logic [RX_INDEX_W-1:0]    rx_index_q, rx_index_d;
  logic                     miso_q, miso_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     frame_start_q, frame_start_d;
  logic                     frame_end_q, frame_end_d;
  logic                     frame_abort_q, frame_abort_d;
  logic                     tx_underrun_q, tx_underrun_d;

  spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(reset), .d_i(spi_sclk), .q_o(sclk_s)
  );
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(reset), .d_i(spi_cs_n), .q_o(cs_n_s)
  );
  spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .d_i(spi_mosi), .q_o(mosi_s)
  );

  assign sclk_rise =  sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s &  sclk_d_q;
  assign cs_rise   =  cs_n_s & ~cs_n_d_q;
  assign cs_fall   = ~cs_n_s &  cs_n_d_q;

  // Frame FSM, bit/byte counters, shifters and output pulses: next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_index_d    = rx_index_q;
    miso_d        = miso_q;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_abort_d = 1'b0;
    tx_underrun_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          byte_cnt_d    = '0;
          rx_shift_d    = '0;
          tx_shift_d    = SPI_IDLE_BYTE;
          rx_index_d    = '0;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          // cs release has priority over any sclk edge seen in the same cycle.
          state_d       = ST_IDLE;
          frame_end_d   = 1'b1;
          frame_abort_d = (bit_cnt_q != '0);
          miso_d        = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-3:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == {BIT_CNT_W{1'b1}}) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            rx_index_d = byte_cnt_q;
            byte_cnt_d = sat_inc(byte_cnt_q);
          end
        end else if (sclk_fall) begin
          // A byte boundary after at least one received byte is where the reply is loaded.
          if ((bit_cnt_q == '0) && (byte_cnt_q != '0)) begin
            if (tx_valid) begin
              tx_shift_d = tx_data;
            end else begin
              tx_shift_d    = SPI_IDLE_BYTE;
              tx_underrun_d = 1'b1;
            end
          end else if (TX_MSB_FIRST) begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[SPI_BYTE_W-1:1]};
          end
          miso_d = TX_MSB_FIRST ? tx_shift_d[SPI_BYTE_W-1] : tx_shift_d[0];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, plus delayed copies of the synchronised pins for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d_q      <= 1'b0;
      cs_n_d_q      <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_index_q    <= '0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_d_q      <= sclk_s;
      cs_n_d_q      <= cs_n_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_index_q    <= rx_index_d;
      miso_q        <= miso_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_abort_q <= frame_abort_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign spi_miso    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_index    = rx_index_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_abort = frame_abort_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_byte_frontend.sv
// Self-checking bench for spi_byte_frontend: an SPI master model drives frames, a consumer
// model supplies reply bytes, and scoreboards compare received bytes and MISO bytes.
module tb_spi_byte_frontend;

  localparam int HALF   = 8;     // clk cycles per sclk half period
  localparam bit TX_MSB = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_index;
  logic       frame_start, frame_end, frame_abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_underrun;

  always #5 clk = ~clk;

  spi_byte_frontend #(.SYNC_STAGES(2), .TX_MSB_FIRST(TX_MSB)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_index(rx_index),
    .frame_start(frame_start), .frame_end(frame_end), .frame_abort(frame_abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_underrun(tx_underrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [7:0] data; logic [3:0] idx; } rx_exp_t;
  typedef struct packed { logic valid; logic [7:0] data; } reply_t;

  rx_exp_t    rx_exp_q[$];
  logic [7:0] miso_exp_q[$];
  reply_t     plan_q[$];
  logic [7:0] frame_bytes[$];

  int   n_start = 0, n_end = 0, n_abort = 0, n_under = 0;
  int   e_start = 0, e_end = 0, e_abort = 0, e_under = 0;
  logic exp_abort_now = 1'b0;
  logic [7:0] last_rx = 8'h00;

  // Output monitor: pops the expected received byte whenever rx_valid is presented.
  rx_exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (rx_valid) begin
        check("rx_valid_expected", 32'(rx_exp_q.size() != 0), 1);
        if (rx_exp_q.size() != 0) begin
          mon_e = rx_exp_q.pop_front();
          check("rx_data", rx_data, mon_e.data);
          check("rx_index", rx_index, mon_e.idx);
        end
      end
      if (frame_start) n_start++;
      if (frame_end) begin
        n_end++;
        check("abort_with_end", frame_abort, exp_abort_now);
        check("miso_zero_at_end", spi_miso, 0);
      end
      if (frame_abort) begin
        n_abort++;
        check("abort_needs_end", frame_end, 1);
      end
      if (tx_underrun) n_under++;
    end
  end

  // Consumer model: after each received byte, offer the next reply (planned or random).
  reply_t rsp;
  initial forever begin
    @(negedge clk);
    if (reset && rx_valid) begin
      if (plan_q.size() != 0) begin
        rsp = plan_q.pop_front();
      end else begin
        rsp.valid = ($urandom_range(0, 3) != 0);
        rsp.data  = 8'($urandom);
      end
      tx_valid = rsp.valid;
      tx_data  = rsp.valid ? rsp.data : 8'($urandom);
      miso_exp_q.push_back(rsp.valid ? rsp.data : 8'h00);
      if (!rsp.valid) e_under++;
    end
  end

  // MISO monitor: the master samples MISO on each sclk rise and compares whole bytes.
  int         mb_n = 0;
  logic [7:0] mb;
  initial forever begin
    @(posedge spi_sclk or posedge spi_cs_n or negedge reset);
    if (!reset || spi_cs_n) begin
      mb_n = 0;
      miso_exp_q.delete();
    end else if (spi_sclk) begin
      mb[TX_MSB ? 7 - mb_n : mb_n] = spi_miso;
      mb_n++;
      if (mb_n == 8) begin
        mb_n = 0;
        check("miso_exp_available", 32'(miso_exp_q.size() != 0), 1);
        if (miso_exp_q.size() != 0) check("miso_byte", mb, miso_exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      wait_clk(HALF);
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic open_frame();
    miso_exp_q.push_back(8'h00);
    e_start++;
    spi_cs_n = 1'b0;
  endtask

  task automatic send_full_byte(input logic [7:0] b, input int pos);
    rx_exp_q.push_back({b, 4'((pos > 15) ? 15 : pos)});
    send_bits(b, 8);
    last_rx = b;
  endtask

  // Drives frame_bytes as full bytes, then 'tail' extra bits, then releases cs_n.
  task automatic run_frame(input int tail);
    open_frame();
    foreach (frame_bytes[i]) send_full_byte(frame_bytes[i], i);
    if (tail > 0) send_bits(8'($urandom), tail);
    wait_clk(HALF);
    exp_abort_now = (tail != 0);
    e_end++;
    if (tail != 0) e_abort++;
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic random_bytes(input int n);
    frame_bytes.delete();
    for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom));
  endtask

  int s0, u0, a0, d0;
  logic [7:0] hold_rx;

  initial begin
    reset    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    wait_clk(3);
    check("reset_miso", spi_miso, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_index", rx_index, 0);
    check("reset_pulses", {rx_valid, frame_start, frame_end, frame_abort, tx_underrun}, 0);
    reset = 1'b1;
    wait_clk(4);

    // Two-byte frame 0x80, 0x7F with reply 0xA5 after byte 0 (LSB first on MISO).
    frame_bytes = '{8'h80, 8'h7F};
    plan_q.push_back({1'b1, 8'hA5});
    plan_q.push_back({1'b1, 8'h3C});
    s0 = n_start; u0 = n_under;
    run_frame(0);
    check("t2_frame_start_once", n_start - s0, 1);
    check("t3_no_underrun", n_under - u0, 0);
    check("t2_rx_data_held", rx_data, 8'h7F);
    check("t2_rx_index_held", rx_index, 1);

    // Reply not ready at the first load point: one underrun, MISO byte 0x00.
    random_bytes(2);
    plan_q.push_back({1'b0, 8'h00});
    plan_q.push_back({1'b1, 8'hC3});
    u0 = n_under;
    run_frame(0);
    check("t4_underrun_once", n_under - u0, 1);

    // cs release after 5 bits of byte 1: abort with end, no extra rx_valid.
    random_bytes(1);
    plan_q.push_back({1'b1, 8'hFF});
    a0 = n_abort; d0 = n_end;
    run_frame(5);
    check("t5_abort_once", n_abort - a0, 1);
    check("t5_end_once", n_end - d0, 1);
    check("t5_miso_idle", spi_miso, 0);

    // Asynchronous reset in the middle of a frame.
    s0 = n_start;
    open_frame();
    send_full_byte(8'($urandom), 0);
    send_bits(8'($urandom), 4);
    reset = 1'b0;
    wait_clk(2);
    check("t1_miso_in_reset", spi_miso, 0);
    spi_cs_n = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    last_rx = 8'h00;
    wait_clk(2 * HALF);
    check("t1_miso_after", spi_miso, 0);
    check("t1_rx_index_after", rx_index, 0);
    check("t1_rx_data_after", rx_data, 0);
    check("t1_no_new_start", n_start - s0, 1);
    random_bytes(3);
    run_frame(0);

    // Long frame: rx_index saturates at 15 for bytes 15..19.
    random_bytes(20);
    run_frame(0);
    check("t6_rx_index_sat", rx_index, 15);

    // sclk/mosi activity with cs_n high must not change anything.
    s0 = n_start; d0 = n_end; a0 = n_abort; u0 = n_under;
    hold_rx = rx_data;
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom);
      wait_clk(HALF);
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    wait_clk(HALF);
    check("t6_idle_events", (n_start - s0) + (n_end - d0) + (n_abort - a0) + (n_under - u0), 0);
    check("t6_idle_rx_data", rx_data, hold_rx);
    check("t6_idle_rx_index", rx_index, 15);
    check("t6_idle_miso", spi_miso, 0);

    // Randomised frames with occasional partial trailing bytes.
    for (int f = 0; f < 8; f++) begin
      random_bytes($urandom_range(1, 5));
      run_frame(($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
    end

    wait_clk(20);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("final_rx_data", rx_data, last_rx);
    check("count_frame_start", n_start, e_start);
    check("count_frame_end", n_end, e_end);
    check("count_frame_abort", n_abort, e_abort);
    check("count_tx_underrun", n_under, e_under);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
